// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_pkg: shared parity codes, tx FSM states, frame sizing helper  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  function automatic int frame_bits(input int data_bits, input int parity_mode,
                                    input int stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_sync_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_sync_fifo: single-clock FIFO, full/empty derived from count   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  assign o_full    = (r_count == c_CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  // A pop in the same cycle never frees room for a push into a full FIFO.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk_in) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmit_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | uart_transmit_fifo: parametrised UART TX fed by a valid/ready FIFO |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module uart_transmit_fifo
  import uart_pkg::*;
#(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 9600,
  parameter int DATA_BITS        = 8,
  parameter int PARITY_MODE      = PARITY_NONE,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [DATA_BITS-1:0]          data_in,
  input  logic                          valid_in,
  output logic                          ready_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          busy_out,
  output logic                          tx_wire_out
);

  localparam int   c_P          = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int   c_BAUD_W     = $clog2(c_P);
  localparam int   c_FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam int   c_BIT_W      = $clog2(c_FRAME_BITS);
  localparam logic c_HAS_PARITY = (PARITY_MODE == PARITY_ODD) || (PARITY_MODE == PARITY_EVEN);
  localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(c_P - 1);
  localparam logic [c_BIT_W-1:0]  c_DATA_LAST = c_BIT_W'(DATA_BITS - 1);
  localparam logic [c_BIT_W-1:0]  c_STOP_LAST = c_BIT_W'(STOP_BITS - 1);

  tx_state_t              r_state, w_state_nxt;
  logic [c_BAUD_W-1:0]    r_baud, w_baud_nxt;
  logic [c_BIT_W-1:0]     r_bit, w_bit_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic                   r_parity, w_parity_nxt;
  logic                   r_tx, w_tx_nxt;
  logic                   w_pop;
  logic                   w_bit_end;
  logic                   w_parity_calc;
  logic [DATA_BITS-1:0]   w_fifo_data;
  logic                   w_full;
  logic                   w_empty;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .i_push   (valid_in),
    .i_data   (data_in),
    .i_pop    (w_pop),
    .o_data   (w_fifo_data),
    .o_count  (fifo_count_out),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  assign ready_out     = !w_full;
  assign busy_out      = (r_state != ST_IDLE);
  assign tx_wire_out   = r_tx;
  assign w_bit_end     = (r_baud == c_BAUD_LAST);
  assign w_parity_calc = (PARITY_MODE == PARITY_ODD) ? ~^w_fifo_data : ^w_fifo_data;

  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;
    w_tx_nxt     = r_tx;
    w_pop        = 1'b0;

    if (r_state != ST_IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_tx_nxt   = 1'b1;
        w_baud_nxt = '0;
        w_pop      = !w_empty;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_nxt = ST_DATA;
          w_bit_nxt   = '0;
          w_tx_nxt    = r_shift[0];
          w_shift_nxt = r_shift >> 1;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit == c_DATA_LAST) begin
            w_bit_nxt = '0;
            if (c_HAS_PARITY) begin
              w_state_nxt = ST_PARITY;
              w_tx_nxt    = r_parity;
            end else begin
              w_state_nxt = ST_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            w_bit_nxt   = r_bit + 1'b1;
            w_tx_nxt    = r_shift[0];
            w_shift_nxt = r_shift >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = ST_STOP;
          w_bit_nxt   = '0;
          w_tx_nxt    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          if (r_bit == c_STOP_LAST) begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = 1'b1;
            w_pop       = !w_empty;
          end else begin
            w_bit_nxt = r_bit + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase

    // Loading the next word overrides the idle return so frames run back to back.
    if (w_pop) begin
      w_state_nxt  = ST_START;
      w_baud_nxt   = '0;
      w_shift_nxt  = w_fifo_data;
      w_parity_nxt = w_parity_calc;
      w_tx_nxt     = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state  <= ST_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_state  <= w_state_nxt;
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
      r_tx     <= w_tx_nxt;
    end
  end

endmodule
`default_nettype wire
